// File: rtl/alu_seq_exec.sv
// RV32 ALU behind a valid/ready handshake; define ALU_SEQ_FAST_SHIFT_EN for a barrel shifter instead of one-bit-per-cycle shifts.
// Latency: 1 cycle for all ops; iterative shifts take shamt+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low while shifting, high in DONE only with out_ready.
module alu_seq_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] res;
  logic [4:0]            cnt;
  logic [3:0]            op_q;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  accept;
  logic                  iter_start;

  assign shamt     = SrcB[4:0];
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign ALUResult = res;
  assign Zero      = (res == '0);

`ifdef ALU_SEQ_FAST_SHIFT_EN
  assign iter_start = 1'b0;
`else
  logic is_shift;
  assign is_shift   = (Operation == 4'b0111) || (Operation == 4'b1110) || (Operation == 4'b1111);
  assign iter_start = is_shift && (shamt != 5'd0);
`endif

  always_comb begin
    alu_out = '0;
    case (Operation)
      4'b0000: alu_out = SrcA & SrcB;
      4'b0001: alu_out = SrcA | SrcB;
      4'b0010: alu_out = SrcA + SrcB;
      4'b0011: alu_out = SrcA + DATA_WIDTH'(4);
      4'b0101: alu_out = SrcA ^ SrcB;
      4'b0110: alu_out = SrcA - SrcB;
      4'b1000: alu_out = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      4'b1001: alu_out = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      4'b1010: alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
      4'b1011: alu_out = SrcB;
      4'b1100: alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_SEQ_FAST_SHIFT_EN
      4'b0111: alu_out = SrcA << shamt;
      4'b1110: alu_out = $signed(SrcA) >>> shamt;
      4'b1111: alu_out = SrcA >> shamt;
`else
      // Only reached with shamt == 0; nonzero shifts go through SHIFT.
      4'b0111, 4'b1110, 4'b1111: alu_out = SrcA;
`endif
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      res   <= '0;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      case (state)
        SHIFT: begin
          case (op_q)
            4'b0111: res <= res << 1;
            4'b1110: res <= {res[DATA_WIDTH-1], res[DATA_WIDTH-1:1]};
            default: res <= res >> 1;
          endcase
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= DONE;
        end
        DONE: begin
          if (out_ready && !accept) state <= IDLE;
        end
        default: ;
      endcase
      // Accept only happens in IDLE/DONE, so it never collides with the SHIFT update.
      if (accept) begin
        if (iter_start) begin
          res   <= SrcA;
          cnt   <= shamt;
          op_q  <= Operation;
          state <= SHIFT;
        end else begin
          res   <= alu_out;
          state <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed scenarios then random ops against a reference model.
module tb_alu_seq_exec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int vectors;
  int miscompares;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [31:0] fill;
    sh = int'(b[4:0]);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a + 32'd4;
      4'd5:    return a ^ b;
      4'd6:    return a - b;
      4'd7:    return a << sh;
      4'd8:    return (a == b) ? 32'd1 : 32'd0;
      4'd9:    return (a != b) ? 32'd1 : 32'd0;
      4'd10:   return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd11:   return b;
      4'd12:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd14:   return (a >> sh) | fill;
      4'd15:   return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'd7 || op == 4'd14 || op == 4'd15) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int low;
    logic [31:0] exp;
    exp = ref_alu(op, a, b);
    chk("ready_before_op", {31'b0, in_ready}, 32'd1);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
    cyc = 1;
    low = 0;
    while (out_valid !== 1'b1 && cyc < 64) begin
      if (in_ready === 1'b0) low++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(ref_lat(op, b)));
    chk("ready_low_cycles", 32'(low), 32'(ref_lat(op, b) - 1));
    chk("result", ALUResult, exp);
    chk("zero", {31'b0, Zero}, {31'b0, exp == 32'd0});
    @(negedge clk);
    chk("back_to_idle", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ea [8];
    logic [31:0] eb [8];
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", {31'b0, Zero}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic ops
    do_op(4'b0010, 32'd5, 32'd7);
    do_op(4'b0110, 32'd9, 32'd9);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'd1);
    do_op(4'b1110, 32'h8000_0000, 32'd4);
    do_op(4'b0111, 32'h0000_0001, 32'd31);
    do_op(4'b1111, 32'hF000_0000, 32'd0);
    do_op(4'b0011, 32'hFFFF_FFFE, 32'd0);
    do_op(4'b1101, 32'h1234_5678, 32'h1);

    // Hold result under backpressure; new requests must not be taken
    Operation = 4'b1011; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5000; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", ALUResult, 32'h1234_5000);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {31'b0, out_valid}, 32'd0);
    chk("hold_after", ALUResult, 32'h1234_5000);

    // Back-to-back ADD stream
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_result", ALUResult, ea[k-1] + eb[k-1]);
      end
      if (k < 8) begin
        ea[k] = $urandom; eb[k] = $urandom;
        chk("b2b_ready", {31'b0, in_ready}, 32'd1);
        Operation = 4'b0010; SrcA = ea[k]; SrcB = eb[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_drain", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a long shift
    Operation = 4'b0111; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    chk("mid_shift_ready", {31'b0, in_ready}, 32'd1);
`else
    chk("mid_shift_ready", {31'b0, in_ready}, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", ALUResult, 32'd0);
    chk("abort_ready", {31'b0, in_ready}, 32'd1);

    // Random ops
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) ra = {1'b1, ra[30:0]};
      do_op(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
